// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM with a stability
// counter, registered press/release strobes and a wrapping press counter.
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  output logic       o_btn_level,
  output logic       o_btn_pulse,
  output logic       o_release_pulse,
  output logic [7:0] o_press_count
);

  localparam logic [1:0] IDLE_LOW   = 2'd0;
  localparam logic [1:0] CHECK_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH  = 2'd2;
  localparam logic [1:0] CHECK_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             release_q;
  logic             release_d;
  logic [7:0]       count_q;
  logic [7:0]       count_d;

  // The raw button is asynchronous; only sync2_q may feed the FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;

    case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = CHECK_HIGH;
          cnt_d   = '0;
        end
      end

      // Any opposite sample restarts detection from the idle state.
      CHECK_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          pulse_d = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      IDLE_HIGH: begin
        if (!sync2_q) begin
          state_d = CHECK_LOW;
          cnt_d   = '0;
        end
      end

      CHECK_LOW: begin
        if (sync2_q) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_LOW;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE_LOW;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  assign o_btn_level     = level_q;
  assign o_btn_pulse     = pulse_q;
  assign o_release_pulse = release_q;
  assign o_press_count   = count_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: run-length reference model compared every cycle,
// directed scenarios with literal expectations, then random bouncy input.
module tb_btn_debounce_pulse;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       btnLevel;
  logic       btnPulse;
  logic       releasePulse;
  logic [7:0] pressCount;

  int checksTotal  = 0;
  int checksPassed = 0;
  int pulseSeen    = 0;
  bit compareEn    = 1'b0;

  logic       mSync1;
  logic       mSync2;
  logic       mLevel;
  logic       mPulse;
  logic       mRelease;
  logic [7:0] mCount;
  int         mRun;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn(btn),
    .o_btn_level(btnLevel),
    .o_btn_pulse(btnPulse),
    .o_release_pulse(releasePulse),
    .o_press_count(pressCount)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Level flips once the observed synchronized value has disagreed with it
  // for DEB+1 consecutive edges; any agreeing sample restarts the run.
  always @(posedge clk) begin
    if (rst) begin
      mSync1 = 1'b0; mSync2 = 1'b0; mLevel = 1'b0;
      mPulse = 1'b0; mRelease = 1'b0; mCount = 8'd0; mRun = 0;
    end else begin
      mPulse   = 1'b0;
      mRelease = 1'b0;
      if (mSync2 != mLevel) begin
        mRun++;
        if (mRun == DEB + 1) begin
          mLevel = mSync2;
          mRun   = 0;
          if (mSync2) begin
            mPulse = 1'b1;
            mCount = mCount + 8'd1;
          end else begin
            mRelease = 1'b1;
          end
        end
      end else begin
        mRun = 0;
      end
      mSync2 = mSync1;
      mSync1 = btn;
    end
  end

  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("model level", 8'(btnLevel), 8'(mLevel));
      checkOutput("model pulse", 8'(btnPulse), 8'(mPulse));
      checkOutput("model release", 8'(releasePulse), 8'(mRelease));
      checkOutput("model count", pressCount, mCount);
      checkOutput("no overlap", 8'(btnPulse & releasePulse), 8'd0);
      if (btnPulse) pulseSeen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    btn = level;
    tick(cycles);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    int p;
    rst = 1'b1;
    btn = 1'b0;
    tick(1);
    compareEn = 1'b1;
    tick(1);
    rst = 1'b0;

    // Idle low after reset
    applyStimulus(1'b0, 20);
    checkOutput("idle level", 8'(btnLevel), 8'd0);
    checkOutput("idle count", pressCount, 8'd0);
    checkOutput("idle pulses", 8'(pulseSeen), 8'd0);

    // Bounce shorter than the debounce window must be rejected
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 12);
    checkOutput("bounce level", 8'(btnLevel), 8'd0);
    checkOutput("bounce count", pressCount, 8'd0);
    checkOutput("bounce pulses", 8'(pulseSeen), 8'd0);

    // Clean press: strobe visible after edge k+6, gone after k+7
    btn = 1'b1;
    tick(6);
    checkOutput("press early pulse", 8'(btnPulse), 8'd0);
    tick(1);
    checkOutput("press level", 8'(btnLevel), 8'd1);
    checkOutput("press pulse", 8'(btnPulse), 8'd1);
    checkOutput("press count", pressCount, 8'd1);
    tick(1);
    checkOutput("press pulse end", 8'(btnPulse), 8'd0);
    tick(12);

    // Release with identical latency
    btn = 1'b0;
    tick(7);
    checkOutput("release pulse", 8'(releasePulse), 8'd1);
    checkOutput("release level", 8'(btnLevel), 8'd0);
    tick(1);
    checkOutput("release pulse end", 8'(releasePulse), 8'd0);
    tick(2);

    // Counter wraps after 256 presses
    doReset();
    checkOutput("wrap start count", pressCount, 8'd0);
    p = pulseSeen;
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 10);
    end
    checkOutput("wrap count", pressCount, 8'd1);
    checkOutput("wrap pulses", 8'((pulseSeen - p) == 257), 8'd1);

    // Reset during CHECK_HIGH with the button held
    doReset();
    applyStimulus(1'b0, 3);
    btn = 1'b1;
    tick(4);
    checkOutput("pre-reset level", 8'(btnLevel), 8'd0);
    rst = 1'b1;
    tick(1);
    checkOutput("reset level", 8'(btnLevel), 8'd0);
    checkOutput("reset pulse", 8'(btnPulse), 8'd0);
    checkOutput("reset release", 8'(releasePulse), 8'd0);
    checkOutput("reset count", pressCount, 8'd0);
    rst = 1'b0;
    p = pulseSeen;
    tick(6);
    checkOutput("post-reset early pulse", 8'(btnPulse), 8'd0);
    tick(1);
    checkOutput("post-reset pulse", 8'(btnPulse), 8'd1);
    checkOutput("post-reset count", pressCount, 8'd1);
    tick(5);
    checkOutput("post-reset pulse total", 8'(pulseSeen - p), 8'd1);

    // Random bouncy input against the model
    doReset();
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end
    applyStimulus(1'b0, 20);
    checkOutput("random final level", 8'(btnLevel), 8'd0);

    compareEn = 1'b0;
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
